neopixel_frame_sched: RTL and testbench
=======================================

NEOPIXEL_FRAME_SCHED -- requirements
Module: neopixel_frame_sched

Interface
REQ-001 SHALL have parameter C_PIXEL_COUNT, default 4: pixels per frame, min 1.
REQ-002 SHALL have parameter C_CONTROL_RATE, default 8000: clock cycles between frame ticks, min 2.
REQ-003 SHALL have parameter C_LATCH_CYCLES, default 6250: low-time latch gap after last bit (50 us at 125 MHz), min 1.
REQ-004 SHALL have port clock_125m  input  1  sole clock; one clock; all logic on its rising edge.
REQ-005 SHALL have port reset_125m  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  frame ticks generated only while high.
REQ-007 SHALL have port pix_rd_en  output  1  pixel buffer read strobe.
REQ-008 SHALL have port pix_rd_addr  output  ADDR_W = max(1, clog2(C_PIXEL_COUNT))  pixel index to read.
REQ-009 SHALL have port pix_rd_data  input  24  GRB pixel, valid the cycle after pix_rd_en.
REQ-010 SHALL have port ser_data  output  24  pixel to serializer.
REQ-011 SHALL have port ser_valid  output  1  ser_data valid.
REQ-012 SHALL have port ser_ready  input  1  serializer accepts when ser_valid && ser_ready.
REQ-013 SHALL have port ser_idle  input  1  serializer has finished shifting all accepted bits.
REQ-014 SHALL have ports frame_start, frame_done, overrun  output  1 each  single-cycle pulses.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 Frame timer SHALL count 0..C_CONTROL_RATE-1 while enable=1 and assert tick for one cycle when count = C_CONTROL_RATE-1, then wrap to 0; enable=0 holds count at 0.
REQ-017 FSM states SHALL be IDLE, FETCH, CAPTURE, SEND, DRAIN, LATCH.
REQ-018 IDLE: tick -> FETCH, index := 0, frame_start pulsed in the FETCH entry cycle.
REQ-019 FETCH (1 cycle): pix_rd_en=1, pix_rd_addr=index -> CAPTURE.
REQ-020 CAPTURE (1 cycle): ser_data := pix_rd_data, ser_valid := 1 -> SEND.
REQ-021 SEND: hold ser_data/ser_valid stable until ser_valid && ser_ready; on handshake, ser_valid := 0; if index = C_PIXEL_COUNT-1 -> DRAIN, else index+1 -> FETCH.
REQ-022 DRAIN: wait for ser_idle=1 (first cycle after last handshake or later) -> LATCH, latch counter := 0.
REQ-023 LATCH: count C_LATCH_CYCLES cycles; on final cycle pulse frame_done and -> IDLE.
REQ-024 Tick while busy=1 SHALL be dropped and pulse overrun the same cycle; frame in progress unaffected.
REQ-025 enable falling mid-frame SHALL NOT truncate the frame; the current frame completes through LATCH.
REQ-026 Tick coincident with the frame_done cycle SHALL count as overrun (FSM not yet in IDLE).
REQ-027 Pixel-to-pixel minimum spacing SHALL be 3 cycles (FETCH, CAPTURE, SEND) with ser_ready held high.
REQ-028 index SHALL never exceed C_PIXEL_COUNT-1; no wrap within a frame.

Reset
REQ-029 reset_125m=1 SHALL force, on the next clock edge: state IDLE, index 0, timer 0, latch counter 0, ser_valid 0, ser_data 0, pix_rd_en 0, pix_rd_addr 0, frame_start/frame_done/overrun 0, busy 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without frame_done; first tick after release occurs C_CONTROL_RATE cycles after release with enable=1.

Structure
REQ-031 Package neopixel_pkg SHALL hold pixel_t (24-bit GRB), the FSM state enum, and default latch/rate constants.
REQ-032 Frame timer SHALL be the sub-module neopixel_frame_timer (count, enable, tick out); all else in neopixel_frame_sched.

Verification (C_PIXEL_COUNT=4, C_CONTROL_RATE=8000, C_LATCH_CYCLES=100)
REQ-033 Buffer = {0x110000, 0x002200, 0x000033, 0xFFFFFF}, ser_ready=1, ser_idle follows serializer model -> one frame_start, four handshakes in address order 0..3 with matching data, frame_done exactly 100 cycles after DRAIN exit.
REQ-034 ser_ready held low 50 cycles during pixel 2 -> ser_data stays 0x000033 and ser_valid stays high throughout; no extra pix_rd_en.
REQ-035 ser_ready=0 permanently for C_CONTROL_RATE cycles -> overrun pulses at each tick, no second frame_start, busy stays high.
REQ-036 Reset asserted during LATCH -> all outputs at reset values next cycle, no frame_done; next frame_start 8000 cycles after release.
REQ-037 enable deasserted during pixel 1 -> frame completes with frame_done; no further frame_start while enable=0.
REQ-038 C_PIXEL_COUNT=1 build -> single handshake per frame, pix_rd_addr always 0.

Source files
------------

// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared pixel type, scheduler states and default timing constants
package neopixel_pkg;
  typedef logic [23:0] pixel_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPTURE, S_SEND, S_DRAIN, S_LATCH} state_t;
  localparam int DEF_PIXEL_COUNT = 4;
  localparam int DEF_CONTROL_RATE = 8000;
  localparam int DEF_LATCH_CYCLES = 6250;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/neopixel_frame_timer.sv
// neopixel_frame_timer: free-running frame tick generator, held at zero while disabled
module neopixel_frame_timer import neopixel_pkg::*; #(
  parameter int C_CONTROL_RATE = DEF_CONTROL_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int W = cnt_w(C_CONTROL_RATE);
  localparam logic [W-1:0] LAST = W'(C_CONTROL_RATE - 1);
  logic [W-1:0] count;
  assign tick = enable && count == LAST;
  always_ff @(posedge clk)
    count <= (rst || !enable || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/neopixel_frame_sched.sv
// neopixel_frame_sched: per-tick frame sequencer fetching pixels from a buffer into a serializer
module neopixel_frame_sched import neopixel_pkg::*; #(
  parameter int C_PIXEL_COUNT = DEF_PIXEL_COUNT,
  parameter int C_CONTROL_RATE = DEF_CONTROL_RATE,
  parameter int C_LATCH_CYCLES = DEF_LATCH_CYCLES,
  localparam int ADDR_W = cnt_w(C_PIXEL_COUNT)
) (
  input  logic              clock_125m,
  input  logic              reset_125m,
  input  logic              enable,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_rd_addr,
  input  logic [23:0]       pix_rd_data,
  output logic [23:0]       ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  input  logic              ser_idle,
  output logic              frame_start,
  output logic              frame_done,
  output logic              overrun,
  output logic              busy
);
  localparam int LW = cnt_w(C_LATCH_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(C_PIXEL_COUNT - 1);
  localparam logic [LW-1:0] LAST_LAT = LW'(C_LATCH_CYCLES - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] index, index_n;
  logic [LW-1:0] latch_cnt, latch_n;
  pixel_t data_n;
  logic valid_n, tick, last_pix, latch_end;
  neopixel_frame_timer #(.C_CONTROL_RATE(C_CONTROL_RATE)) u_timer (
    .clk(clock_125m),
    .rst(reset_125m),
    .enable(enable),
    .tick(tick)
  );
  assign last_pix = index == LAST_PIX;
  assign latch_end = latch_cnt == LAST_LAT;
  assign busy = state != S_IDLE;
  assign overrun = tick && busy;
  assign pix_rd_en = state == S_FETCH;
  assign pix_rd_addr = pix_rd_en ? index : '0;
  assign frame_done = state == S_LATCH && latch_end;
  always_ff @(posedge clock_125m) begin
    if (reset_125m) begin
      state <= S_IDLE;
      index <= '0;
      latch_cnt <= '0;
      ser_data <= '0;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      index <= index_n;
      latch_cnt <= latch_n;
      ser_data <= data_n;
      ser_valid <= valid_n;
      frame_start <= state == S_IDLE && tick;
    end
  end
  // ser_valid is always high in SEND, so ser_ready alone completes the handshake
  always_comb begin
    state_n = state;
    index_n = index;
    latch_n = latch_cnt;
    data_n = ser_data;
    valid_n = ser_valid;
    case (state)
      S_IDLE: begin
        state_n = tick ? S_FETCH : S_IDLE;
        index_n = tick ? '0 : index;
      end
      S_FETCH: state_n = S_CAPTURE;
      S_CAPTURE: begin
        data_n = pix_rd_data;
        valid_n = 1'b1;
        state_n = S_SEND;
      end
      S_SEND: if (ser_ready) begin
        valid_n = 1'b0;
        state_n = last_pix ? S_DRAIN : S_FETCH;
        index_n = last_pix ? index : index + 1'b1;
      end
      S_DRAIN: if (ser_idle) begin
        state_n = S_LATCH;
        latch_n = '0;
      end
      S_LATCH: begin
        state_n = latch_end ? S_IDLE : S_LATCH;
        latch_n = latch_end ? latch_cnt : latch_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_neopixel_frame_sched.sv
// tb_neopixel_frame_sched: timestamp-level frame model plus directed scenarios for the frame scheduler
module tb_neopixel_frame_sched;
  localparam int N = 4, RATE = 8000, LAT = 100, SHIFT = 30;
  logic [23:0] px [4] = '{24'h110000, 24'h002200, 24'h000033, 24'hFFFFFF};
  logic clk = 1'b0, reset_125m = 1'b1, enable = 1'b1, rdy = 1'b1;
  logic pix_rd_en, ser_valid, ser_idle, frame_start, frame_done, overrun, busy;
  logic [1:0] pix_rd_addr;
  logic [23:0] pix_rd_data = '0, ser_data;
  logic u1_rd_en, u1_valid, u1_start, u1_done, u1_ovr, u1_busy;
  logic [0:0] u1_addr;
  logic [23:0] u1_data;
  int sh = 0;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, run = 0, p = 0, f = 0, m_d = -1, start_at = -1;
  bit m_busy = 0, last = 0, was_rst = 0, await_exit = 0, tick_e, rd_e, val_e;
  int n_start = 0, n_done = 0, n_rd = 0, n_ovr = 0, n_idle = 0, n_v33 = 0, fh = 0, fh1 = 0;
  int st_cyc = 0, rel_cyc = 0, dn_cyc = 0, exit_cyc = 0;
  logic [23:0] q [$];
  int aq [$];

  always #5 clk = ~clk;

  neopixel_frame_sched #(.C_PIXEL_COUNT(N), .C_CONTROL_RATE(RATE), .C_LATCH_CYCLES(LAT)) dut (
    .clock_125m(clk), .reset_125m(reset_125m), .enable(enable),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(rdy), .ser_idle(ser_idle),
    .frame_start(frame_start), .frame_done(frame_done), .overrun(overrun), .busy(busy)
  );

  neopixel_frame_sched #(.C_PIXEL_COUNT(1), .C_CONTROL_RATE(20), .C_LATCH_CYCLES(5)) u1 (
    .clock_125m(clk), .reset_125m(reset_125m), .enable(1'b1),
    .pix_rd_en(u1_rd_en), .pix_rd_addr(u1_addr), .pix_rd_data(24'hABCDEF),
    .ser_data(u1_data), .ser_valid(u1_valid), .ser_ready(1'b1), .ser_idle(1'b1),
    .frame_start(u1_start), .frame_done(u1_done), .overrun(u1_ovr), .busy(u1_busy)
  );

  always_ff @(posedge clk) if (pix_rd_en) pix_rd_data <= px[pix_rd_addr];
  // serializer: each accepted pixel adds SHIFT cycles of shifting work
  always_ff @(posedge clk) sh <= sh - (sh != 0 ? 1 : 0) + (ser_valid && rdy ? SHIFT : 0);
  assign ser_idle = sh == 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int get(input int w);
    return w == 0 ? n_start : w == 1 ? n_done : fh;
  endfunction

  task automatic wait_until(input string nm, input int w, input int target, input int lim);
    for (int i = 0; i < lim && get(w) < target; i++) step();
    chk(nm, get(w) >= target, 1'b1);
  endtask

  // model: a frame is a timeline of fetch stamps per pixel, then drain exit + LAT
  always @(negedge clk) begin
    if (reset_125m) begin
      run = 0; m_busy = 0; last = 0; m_d = -1; start_at = -1; was_rst = 1; await_exit = 0;
    end else begin
      if (was_rst) rel_cyc = cyc;
      was_rst = 0;
      tick_e = enable && run % RATE == RATE - 1;
      rd_e = m_busy && !last && cyc == f;
      val_e = m_busy && !last && cyc >= f + 2;
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_busy && tick_e);
      chk("frame_start", frame_start, cyc == start_at);
      chk("frame_done", frame_done, m_busy && cyc == m_d);
      chk("pix_rd_en", pix_rd_en, rd_e);
      chk("ser_valid", ser_valid, val_e);
      if (rd_e) chk("pix_rd_addr", pix_rd_addr, p);
      if (val_e) chk("ser_data", ser_data, px[p]);
      if (frame_start) begin n_start++; st_cyc = cyc; fh = 0; end
      if (await_exit && ser_idle) begin exit_cyc = cyc; await_exit = 0; end
      if (ser_valid && rdy) begin fh++; q.push_back(ser_data); if (fh == N) await_exit = 1; end
      if (frame_done) begin n_done++; dn_cyc = cyc; end
      if (overrun) n_ovr++;
      if (pix_rd_en) begin n_rd++; aq.push_back(int'(pix_rd_addr)); end
      if (!busy) n_idle++;
      if (ser_valid && ser_data == 24'h000033) n_v33++;
      if (!m_busy) begin
        if (tick_e) begin m_busy = 1; p = 0; f = cyc + 1; last = 0; m_d = -1; start_at = cyc + 1; end
      end else if (!last) begin
        if (val_e && rdy) begin
          if (p == N - 1) last = 1;
          else begin p++; f = cyc + 1; end
        end
      end else if (m_d < 0) begin
        if (ser_idle) m_d = cyc + LAT;
      end else if (cyc == m_d) m_busy = 0;
      run = enable ? run + 1 : 0;
    end
    cyc++;
  end

  always @(negedge clk) if (!reset_125m) begin
    chk("p1_addr", u1_addr, 1'b0);
    if (u1_start) fh1 = 0;
    if (u1_valid) begin fh1++; chk("p1_data", u1_data, 24'hABCDEF); end
    if (u1_done) begin
      chk("p1_hs_per_frame", fh1, 1);
      chk("p1_busy", u1_busy, 1'b1);
      chk("p1_overrun", u1_ovr, 1'b0);
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_valid"}, ser_valid, 1'b0);
    chk({nm, "_data"}, ser_data, 24'h0);
    chk({nm, "_rd_en"}, pix_rd_en, 1'b0);
    chk({nm, "_addr"}, pix_rd_addr, 2'd0);
    chk({nm, "_pulses"}, {frame_start, frame_done, overrun}, 3'b000);
  endtask

  initial begin
    int s0, d0, r0, v0, o0, i0;
    repeat (5) step();
    chk_reset_vals("reset");
    reset_125m = 1'b0;
    // frame 1: nominal, ready always high
    wait_until("f1_start", 0, 1, RATE + 100);
    chk("f1_start_delay", st_cyc - rel_cyc, RATE);
    wait_until("f1_done", 1, 1, 2000);
    chk("f1_hs_count", q.size(), 4);
    for (int i = 0; i < 4; i++) chk("f1_hs_data", q[i], px[i]);
    chk("f1_rd_count", aq.size(), 4);
    for (int i = 0; i < 4; i++) chk("f1_rd_addr", aq[i], i);
    chk("f1_latch_gap", dn_cyc - exit_cyc, LAT);
    chk("f1_latch_literal", q[2], 24'h000033);
    // frame 2: backpressure for 50 cycles on pixel 2
    q.delete(); s0 = n_start; d0 = n_done; r0 = n_rd; v0 = n_v33;
    wait_until("f2_start", 0, s0 + 1, RATE + 100);
    wait_until("f2_pix2", 2, 2, 100);
    rdy = 1'b0;
    repeat (50) step();
    rdy = 1'b1;
    wait_until("f2_done", 1, d0 + 1, 2000);
    chk("f2_stall_valid_cycles", n_v33 - v0, 49);
    chk("f2_reads", n_rd - r0, 4);
    chk("f2_hs_count", q.size(), 4);
    chk("f2_pix2", q[2], 24'h000033);
    // frame 3: serializer never ready across two tick periods
    s0 = n_start; d0 = n_done;
    wait_until("f3_start", 0, s0 + 1, RATE + 100);
    rdy = 1'b0;
    s0 = n_start; o0 = n_ovr; i0 = n_idle;
    repeat (2 * RATE) step();
    chk("f3_overruns", n_ovr - o0, 2);
    chk("f3_no_restart", n_start - s0, 0);
    chk("f3_busy_held", n_idle - i0, 0);
    rdy = 1'b1;
    wait_until("f3_done", 1, d0 + 1, 2000);
    // frame 4: reset in the middle of the latch gap
    s0 = n_start;
    wait_until("f4_start", 0, s0 + 1, RATE + 100);
    for (int i = 0; i < 2000 && !(m_d > 0 && cyc >= m_d - 50); i++) step();
    chk("f4_in_latch", m_d > 0 && cyc >= m_d - 50, 1'b1);
    d0 = n_done;
    reset_125m = 1'b1;
    step();
    reset_125m = 1'b0;
    chk_reset_vals("midreset");
    s0 = n_start;
    wait_until("f5_start", 0, s0 + 1, RATE + 100);
    chk("f4_no_done", n_done - d0, 0);
    chk("f5_start_delay", st_cyc - rel_cyc, RATE);
    // frame 5: enable drops during pixel 1, frame still completes
    d0 = n_done;
    wait_until("f5_pix1", 2, 1, 100);
    enable = 1'b0;
    wait_until("f5_done", 1, d0 + 1, 2000);
    chk("f5_hs_count", fh, 4);
    s0 = n_start;
    repeat (RATE + 500) step();
    chk("f5_no_restart", n_start - s0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
